// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
//
// Purpose:
//   Receives PS/2 keyboard frames for the calculator's keyboard decoder.
//   PS2Clk and PS2Data are brought into the FPGAClk domain, PS2Clk falling
//   edges are detected, and 11-bit frames (start, 8 data LSB first, odd
//   parity, stop) are assembled and checked. Stalled frames are abandoned
//   after TIMEOUT_CYCLES. Good bytes are offered on a valid/ready handshake.
//
// Ports:
//   FPGAClk     in   system clock (only clock)
//   rst         in   synchronous active-low reset
//   PS2Clk      in   asynchronous PS/2 clock
//   PS2Data     in   asynchronous PS/2 data
//   data_out    out  received byte (bit 0 = first data bit)
//   data_valid  out  data_out holds an unconsumed byte
//   data_ready  in   consumer takes the byte when data_valid && data_ready
//   parity_err  out  one-cycle pulse, frame failed odd parity
//   frame_err   out  one-cycle pulse, bad stop bit or timeout
//   overrun     out  one-cycle pulse, good frame dropped (byte still held)
//   bit_count   out  falling edges accepted in the current frame, 0..11
//
// Parameters:
//   SYNC_STAGES     synchroniser depth per input (minimum 2)
//   TIMEOUT_CYCLES  idle cycles inside a frame before it is abandoned
//   FILTER_LEN      stable cycles needed before a new PS2Clk level is taken
//
// Optional feature:
//   Define PS2_GLITCH_FILTER_EN to insert a stability filter on the
//   synchronised PS2Clk. Without it the edge detector sees the synchronised
//   level directly.
// ---------------------------------------------------------------------------
module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       FPGAClk,
    input  logic       rst,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic [3:0] bit_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] dataSync_q;
    logic                   clkSynced;
    logic                   dataSynced;
    logic                   clkLevel;
    logic                   prevClk_q;
    logic                   fallEdge;

    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bitCnt_q, bitCnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    dataOut_q, dataOut_d;
    logic          valid_q, valid_d;
    logic          parErr_q, parErr_d;
    logic          frmErr_q, frmErr_d;
    logic          ovr_q, ovr_d;

    // Synchroniser chains. They reset to 1 so that leaving reset never
    // looks like a falling edge on an idle (high) bus.
    always_ff @(posedge FPGAClk) begin
        if (!rst) begin
            clkSync_q  <= '1;
            dataSync_q <= '1;
        end else begin
            clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], PS2Clk};
            dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], PS2Data};
        end
    end

    assign clkSynced  = clkSync_q[SYNC_STAGES-1];
    assign dataSynced = dataSync_q[SYNC_STAGES-1];

`ifdef PS2_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    logic          filtLevel_q;
    logic [FW-1:0] stableCnt_q;

    // The filtered level only follows the synchronised clock once the new
    // level has been present for FILTER_LEN consecutive cycles; any return
    // to the current level restarts the count, so short spikes vanish.
    always_ff @(posedge FPGAClk) begin
        if (!rst) begin
            filtLevel_q <= 1'b1;
            stableCnt_q <= '0;
        end else if (clkSynced == filtLevel_q) begin
            stableCnt_q <= '0;
        end else if (stableCnt_q == FILT_LAST) begin
            filtLevel_q <= clkSynced;
            stableCnt_q <= '0;
        end else begin
            stableCnt_q <= stableCnt_q + 1'b1;
        end
    end

    assign clkLevel = filtLevel_q;
`else
    // FILTER_LEN has no effect without the glitch filter.
    if (FILTER_LEN < 1) begin : gFilterLenUnused
    end

    assign clkLevel = clkSynced;
`endif

    // Previous clock level for edge detection; idle high out of reset.
    always_ff @(posedge FPGAClk) begin
        if (!rst) begin
            prevClk_q <= 1'b1;
        end else begin
            prevClk_q <= clkLevel;
        end
    end

    assign fallEdge = prevClk_q & ~clkLevel;

    // Frame state register and output registers.
    always_ff @(posedge FPGAClk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            timer_q   <= '0;
            dataOut_q <= '0;
            valid_q   <= 1'b0;
            parErr_q  <= 1'b0;
            frmErr_q  <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitCnt_q  <= bitCnt_d;
            timer_q   <= timer_d;
            dataOut_q <= dataOut_d;
            valid_q   <= valid_d;
            parErr_q  <= parErr_d;
            frmErr_q  <= frmErr_d;
            ovr_q     <= ovr_d;
        end
    end

    // Next-state logic. shift_q collects the ten bits after the start bit,
    // entering at the top, so once full: [7:0] data, [8] parity, [9] stop.
    // The timer counts idle cycles since the last edge; the abandon fires in
    // the cycle where the count would reach TIMEOUT_CYCLES, so frame_err is
    // seen exactly TIMEOUT_CYCLES cycles after bit_count last advanced.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitCnt_d  = bitCnt_q;
        timer_d   = '0;
        dataOut_d = dataOut_q;
        valid_d   = valid_q;
        parErr_d  = 1'b0;
        frmErr_d  = 1'b0;
        ovr_d     = 1'b0;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fallEdge && !dataSynced) begin
                    state_d  = RECV;
                    bitCnt_d = 4'd1;
                end
            end

            RECV: begin
                if (fallEdge) begin
                    shift_d  = {dataSynced, shift_q[9:1]};
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd10) begin
                        state_d = CHECK;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = IDLE;
                    frmErr_d = 1'b1;
                    bitCnt_d = '0;
                end else begin
                    timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
                end
            end

            CHECK: begin
                frmErr_d = ~shift_q[9];
                parErr_d = ~(^shift_q[8:0]);
                if (shift_q[9] && (^shift_q[8:0])) begin
                    // A consumer taking the old byte in this very cycle
                    // frees the slot, so the new byte replaces it directly.
                    if (!valid_q || data_ready) begin
                        dataOut_d = shift_q[7:0];
                        valid_d   = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                state_d  = IDLE;
                bitCnt_d = '0;
            end

            default: begin
                state_d  = IDLE;
                bitCnt_d = '0;
            end
        endcase
    end

    assign data_out   = dataOut_q;
    assign data_valid = valid_q;
    assign parity_err = parErr_q;
    assign frame_err  = frmErr_q;
    assign overrun    = ovr_q;
    assign bit_count  = bitCnt_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_frame_rx
//
// Self-checking bench for ps2_frame_rx (TIMEOUT_CYCLES = 1000). PS/2 frames
// are generated at a slow bit rate; expected bytes and error pulses come
// from a frame-level model (odd parity via $countones, stop bit value,
// one-byte holding slot).
// ---------------------------------------------------------------------------
module tb_ps2_frame_rx;

    localparam int TIMEOUT = 1000;

    logic       FPGAClk    = 1'b0;
    logic       rst        = 1'b0;
    logic       PS2Clk     = 1'b1;
    logic       PS2Data    = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic [3:0] bit_count;

    int checks = 0;
    int fails  = 0;

    int pErrTotal      = 0;
    int fErrTotal      = 0;
    int ovrTotal       = 0;
    int longPulseTotal = 0;
    logic prevPe = 1'b0;
    logic prevFe = 1'b0;
    logic prevOv = 1'b0;

    logic       expValid = 1'b0;
    logic [7:0] expData  = 8'h00;

    ps2_frame_rx #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_LEN    (4)
    ) dut (
        .FPGAClk   (FPGAClk),
        .rst       (rst),
        .PS2Clk    (PS2Clk),
        .PS2Data   (PS2Data),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .bit_count (bit_count)
    );

    always #5 FPGAClk = ~FPGAClk;

    // Pulse monitor: counts cycles each pulse output is high and how often
    // a pulse stays high for a second consecutive cycle.
    always @(negedge FPGAClk) begin
        if (parity_err === 1'b1) pErrTotal++;
        if (frame_err === 1'b1) fErrTotal++;
        if (overrun === 1'b1) ovrTotal++;
        if ((parity_err === 1'b1 && prevPe === 1'b1) ||
            (frame_err === 1'b1 && prevFe === 1'b1) ||
            (overrun === 1'b1 && prevOv === 1'b1)) longPulseTotal++;
        prevPe = parity_err;
        prevFe = frame_err;
        prevOv = overrun;
    end

    // Global guard so the run can never hang.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge FPGAClk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        PS2Data = b;
        waitCycles(8);
        PS2Clk = 1'b0;
        waitCycles(16);
        PS2Clk = 1'b1;
        waitCycles(8);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic parBit, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        sendBit(parBit);
        sendBit(stopBit);
        PS2Data = 1'b1;
    endtask

    task automatic consumeByte();
        data_ready = 1'b1;
        waitCycles(1);
        data_ready = 1'b0;
    endtask

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic oddParBit(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        waitCycles(3);
        checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (data_out !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00", data_out); end
        checks++; if (parity_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_parity_err: got %b expected 0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (bit_count !== 4'd0) begin fails++; $display("[TB] FAIL reset_bit_count: got %0d expected 0", bit_count); end
        rst = 1'b1;
        waitCycles(5);
    endtask

    task automatic test_good_frame();
        int pe0 = pErrTotal;
        int fe0 = fErrTotal;
        int seen = 0;
        fork
            sendFrame(8'h1C, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 2000 && seen == 0; i++) begin
                    @(negedge FPGAClk);
                    if (bit_count === 4'd11) seen = 1;
                end
                checks++; if (seen == 0) begin fails++; $display("[TB] FAIL good_eleventh_edge: got no bit_count=11 expected one within 2000 cycles"); end
                if (seen != 0) begin
                    checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL good_valid_early: got %b expected 0 in check cycle", data_valid); end
                    @(negedge FPGAClk);
                    checks++; if (data_valid !== 1'b1) begin fails++; $display("[TB] FAIL good_valid_latency: got %b expected 1", data_valid); end
                end
            end
        join
        checks++; if (data_out !== 8'h1C) begin fails++; $display("[TB] FAIL good_data: got %h expected 1c", data_out); end
        checks++; if ((pErrTotal - pe0) != 0 || (fErrTotal - fe0) != 0) begin fails++; $display("[TB] FAIL good_no_errors: got %0d/%0d pulses expected 0/0", pErrTotal - pe0, fErrTotal - fe0); end
        consumeByte();
        checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL good_consume: got %b expected 0", data_valid); end
    endtask

    task automatic test_parity_error();
        int pe0 = pErrTotal;
        int fe0 = fErrTotal;
        sendFrame(8'h1C, 1'b1, 1'b1);
        waitCycles(4);
        checks++; if ((pErrTotal - pe0) != 1) begin fails++; $display("[TB] FAIL parity_pulse: got %0d pulses expected 1", pErrTotal - pe0); end
        checks++; if ((fErrTotal - fe0) != 0) begin fails++; $display("[TB] FAIL parity_no_frame_err: got %0d expected 0", fErrTotal - fe0); end
        checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL parity_valid: got %b expected 0", data_valid); end
        checks++; if (bit_count !== 4'd0) begin fails++; $display("[TB] FAIL parity_bit_count: got %0d expected 0", bit_count); end
    endtask

    task automatic test_stop_and_stray();
        int pe0 = pErrTotal;
        int fe0 = fErrTotal;
        int ov0 = ovrTotal;
        sendFrame(8'h1C, 1'b0, 1'b0);
        waitCycles(4);
        checks++; if ((fErrTotal - fe0) != 1) begin fails++; $display("[TB] FAIL stop_pulse: got %0d pulses expected 1", fErrTotal - fe0); end
        checks++; if ((pErrTotal - pe0) != 0) begin fails++; $display("[TB] FAIL stop_no_parity_err: got %0d expected 0", pErrTotal - pe0); end
        checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL stop_valid: got %b expected 0", data_valid); end
        pe0 = pErrTotal;
        fe0 = fErrTotal;
        sendBit(1'b1);
        waitCycles(4);
        checks++; if (bit_count !== 4'd0) begin fails++; $display("[TB] FAIL stray_bit_count: got %0d expected 0", bit_count); end
        checks++; if ((pErrTotal - pe0) + (fErrTotal - fe0) + (ovrTotal - ov0) != 0) begin fails++; $display("[TB] FAIL stray_pulses: got %0d expected 0", (pErrTotal - pe0) + (fErrTotal - fe0) + (ovrTotal - ov0)); end
        checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL stray_valid: got %b expected 0", data_valid); end
    endtask

    task automatic test_timeout();
        int fe0 = fErrTotal;
        int c5 = -1;
        int cf = -1;
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        PS2Data = 1'b1;
        waitCycles(8);
        PS2Clk = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge FPGAClk);
            if (i == 16) PS2Clk = 1'b1;
            if (c5 < 0 && bit_count === 4'd5) c5 = i;
            if (c5 >= 0 && frame_err === 1'b1) begin
                cf = i;
                break;
            end
        end
        checks++; if (c5 < 0 || cf < 0) begin fails++; $display("[TB] FAIL timeout_seen: got c5=%0d cf=%0d expected both found", c5, cf); end
        checks++; if ((cf - c5) != TIMEOUT) begin fails++; $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", cf - c5, TIMEOUT); end
        checks++; if (bit_count !== 4'd0) begin fails++; $display("[TB] FAIL timeout_bit_count: got %0d expected 0", bit_count); end
        waitCycles(4);
        checks++; if ((fErrTotal - fe0) != 1) begin fails++; $display("[TB] FAIL timeout_pulse: got %0d pulses expected 1", fErrTotal - fe0); end
        sendFrame(8'h5A, oddParBit(8'h5A), 1'b1);
        waitCycles(4);
        checks++; if (data_valid !== 1'b1 || data_out !== 8'h5A) begin fails++; $display("[TB] FAIL timeout_recover: got valid=%b data=%h expected 1/5a", data_valid, data_out); end
        consumeByte();
    endtask

    task automatic test_overrun();
        int ov0 = ovrTotal;
        int seen = 0;
        sendFrame(8'h16, oddParBit(8'h16), 1'b1);
        waitCycles(4);
        checks++; if (data_valid !== 1'b1 || data_out !== 8'h16) begin fails++; $display("[TB] FAIL ovr_first: got valid=%b data=%h expected 1/16", data_valid, data_out); end
        sendFrame(8'h1E, oddParBit(8'h1E), 1'b1);
        waitCycles(4);
        checks++; if ((ovrTotal - ov0) != 1) begin fails++; $display("[TB] FAIL ovr_pulse: got %0d pulses expected 1", ovrTotal - ov0); end
        checks++; if (data_out !== 8'h16 || data_valid !== 1'b1) begin fails++; $display("[TB] FAIL ovr_hold: got valid=%b data=%h expected 1/16", data_valid, data_out); end
        fork
            sendFrame(8'h1E, oddParBit(8'h1E), 1'b1);
            begin
                for (int i = 0; i < 2000 && seen == 0; i++) begin
                    @(negedge FPGAClk);
                    if (bit_count === 4'd11) seen = 1;
                end
                data_ready = 1'b1;
                @(negedge FPGAClk);
                data_ready = 1'b0;
            end
        join
        waitCycles(4);
        checks++; if (seen == 0) begin fails++; $display("[TB] FAIL ovr_check_cycle: got no bit_count=11 expected one within 2000 cycles"); end
        checks++; if (data_out !== 8'h1E || data_valid !== 1'b1) begin fails++; $display("[TB] FAIL ovr_reload: got valid=%b data=%h expected 1/1e", data_valid, data_out); end
        checks++; if ((ovrTotal - ov0) != 1) begin fails++; $display("[TB] FAIL ovr_no_second: got %0d pulses expected 1", ovrTotal - ov0); end
        consumeByte();
    endtask

    task automatic test_reset_midframe();
        int total0 = pErrTotal + fErrTotal + ovrTotal;
        sendBit(1'b0);
        for (int i = 0; i < 5; i++) sendBit(1'b1);
        checks++; if (bit_count !== 4'd6) begin fails++; $display("[TB] FAIL mid_bit_count: got %0d expected 6", bit_count); end
        rst = 1'b0;
        waitCycles(1);
        rst = 1'b1;
        checks++; if (bit_count !== 4'd0) begin fails++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", bit_count); end
        waitCycles(TIMEOUT + 20);
        checks++; if ((pErrTotal + fErrTotal + ovrTotal) - total0 != 0) begin fails++; $display("[TB] FAIL mid_no_pulses: got %0d expected 0", (pErrTotal + fErrTotal + ovrTotal) - total0); end
        checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_valid: got %b expected 0", data_valid); end
    endtask

`ifdef PS2_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic [7:0] d = 8'hA5;
        sendBit(1'b0);
        sendBit(d[0]);
        sendBit(d[1]);
        PS2Clk = 1'b0;
        waitCycles(2);
        PS2Clk = 1'b1;
        waitCycles(12);
        checks++; if (bit_count !== 4'd3) begin fails++; $display("[TB] FAIL glitch_bit_count: got %0d expected 3", bit_count); end
        for (int i = 2; i < 8; i++) sendBit(d[i]);
        sendBit(oddParBit(d));
        sendBit(1'b1);
        PS2Data = 1'b1;
        waitCycles(4);
        checks++; if (data_valid !== 1'b1 || data_out !== d) begin fails++; $display("[TB] FAIL glitch_frame: got valid=%b data=%h expected 1/%h", data_valid, data_out, d); end
        consumeByte();
    endtask
`endif

    task automatic test_random_frames();
        logic [7:0] d;
        bit [1:0]   mode;
        logic       parBit;
        logic       stopBit;
        bit         doConsume;
        int         expPe, expFe, expOv;
        int         pe0, fe0, ov0;
        expValid = 1'b0;
        for (int n = 0; n < 12; n++) begin
            d         = 8'($urandom_range(0, 255));
            mode      = 2'($urandom_range(0, 3));
            doConsume = 1'($urandom_range(0, 1));
            parBit    = oddParBit(d) ^ mode[0];
            stopBit   = ~mode[1];
            expPe = ((($countones(d) + int'(parBit)) % 2) == 0) ? 1 : 0;
            expFe = (stopBit == 1'b0) ? 1 : 0;
            expOv = 0;
            if (expPe == 0 && expFe == 0) begin
                if (expValid) expOv = 1;
                else begin
                    expValid = 1'b1;
                    expData  = d;
                end
            end
            pe0 = pErrTotal;
            fe0 = fErrTotal;
            ov0 = ovrTotal;
            sendFrame(d, parBit, stopBit);
            waitCycles(4);
            checks++; if ((pErrTotal - pe0) != expPe) begin fails++; $display("[TB] FAIL rand_parity_err #%0d: got %0d expected %0d", n, pErrTotal - pe0, expPe); end
            checks++; if ((fErrTotal - fe0) != expFe) begin fails++; $display("[TB] FAIL rand_frame_err #%0d: got %0d expected %0d", n, fErrTotal - fe0, expFe); end
            checks++; if ((ovrTotal - ov0) != expOv) begin fails++; $display("[TB] FAIL rand_overrun #%0d: got %0d expected %0d", n, ovrTotal - ov0, expOv); end
            checks++; if (data_valid !== expValid) begin fails++; $display("[TB] FAIL rand_valid #%0d: got %b expected %b", n, data_valid, expValid); end
            if (expValid) begin
                checks++; if (data_out !== expData) begin fails++; $display("[TB] FAIL rand_data #%0d: got %h expected %h", n, data_out, expData); end
            end
            checks++; if (bit_count !== 4'd0) begin fails++; $display("[TB] FAIL rand_bit_count #%0d: got %0d expected 0", n, bit_count); end
            if (doConsume && expValid) begin
                consumeByte();
                expValid = 1'b0;
                checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL rand_consume #%0d: got %b expected 0", n, data_valid); end
            end
        end
        if (expValid) consumeByte();
    endtask

    task automatic test_pulse_width();
        checks++; if (longPulseTotal != 0) begin fails++; $display("[TB] FAIL pulse_width: got %0d multi-cycle pulses expected 0", longPulseTotal); end
    endtask

    initial begin
        $display("[TB] starting ps2_frame_rx bench");
        test_reset();
        test_good_frame();
        test_parity_error();
        test_stop_and_stray();
        test_timeout();
        test_overrun();
        test_reset_midframe();
`ifdef PS2_GLITCH_FILTER_EN
        test_glitch();
`endif
        test_random_frames();
        test_pulse_width();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
Parametrised successor to the PS/2 clock synchroniser/counter. Brings asynchronous PS2Clk and PS2Data into the FPGAClk domain through a configurable synchroniser and detects falling edges of PS2Clk. Assembles 11-bit PS/2 frames, checks the start, stop and odd-parity bits, and recovers from stalled frames with a timeout. Delivers each byte to the calculator's keyboard decoder over a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages on each asynchronous input (minimum 2).
TIMEOUT_CYCLES, 200000, FPGAClk cycles without a PS2Clk falling edge before a partial frame is abandoned.
FILTER_LEN, 4, consecutive stable cycles a new PS2Clk level must hold before it is accepted. Used only with PS2_GLITCH_FILTER_EN.

Ports:
FPGAClk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-low reset.
PS2Clk  input  1  asynchronous PS/2 clock.
PS2Data  input  1  asynchronous PS/2 data.
data_out  output  8  received byte, LSB = first data bit.
data_valid  output  1  data_out holds an unconsumed byte.
data_ready  input  1  consumer accepts the byte when data_valid && data_ready.
parity_err  output  1  one-cycle pulse: frame rejected, odd parity failed.
frame_err  output  1  one-cycle pulse: frame rejected, bad stop bit or timeout.
overrun  output  1  one-cycle pulse: good frame dropped because the held byte was not consumed.
bit_count  output  4  falling edges accepted in the current frame, 0..11.

Behaviour:
- Reset (rst=0 at a FPGAClk rising edge):
  - state=IDLE; data_out=0x00; data_valid=0; parity_err=0; frame_err=0; overrun=0; bit_count=0.
  - Timeout counter=0. All synchroniser stages are set to 1 (PS/2 idle level).
  - Reset mid-frame discards the partial frame without any error pulse.
- Synchronisation: PS2Clk and PS2Data each pass through SYNC_STAGES flops.
- Edge detection:
  - A falling edge is detected in the cycle where the registered previous clock level is 1 and the current level is 0.
  - The current level is the filtered level when PS2_GLITCH_FILTER_EN is defined, otherwise the synchronised level.
  - The bit value is the synchronised PS2Data in the edge-detect cycle.
- States:
  - IDLE: on an edge with bit=0 (start), go to RECV and set bit_count=1. On an edge with bit=1, stay in IDLE; no pulse, bit_count stays 0.
  - RECV: each edge shifts in the bit and increments bit_count. On the edge that makes bit_count=11, go to CHECK.
  - RECV timeout: the timeout counter clears on every edge and increments otherwise. When it reaches TIMEOUT_CYCLES, go to IDLE, pulse frame_err, set bit_count=0.
  - CHECK (exactly one cycle): evaluate stop and parity (below), then go to IDLE with bit_count=0.
- Frame checks in CHECK:
  - stop bit = 0 -> frame_err pulse.
  - Ones count over the 8 data bits plus the parity bit is even -> parity_err pulse.
  - Both failures pulse both signals in the same cycle. A failed frame never raises data_valid.
- Handshake on a good frame in CHECK:
  - If data_valid=0, or data_valid=1 with data_ready=1 in the same cycle: load data_out and keep data_valid=1. New data is visible the cycle after CHECK, i.e. two cycles after the 11th edge is detected.
  - If data_valid=1 and data_ready=0: keep the old byte and pulse overrun.
- data_valid clears the cycle after a data_valid && data_ready handshake, unless a reload happens in that same cycle.
- data_out stays stable while data_valid=1.
- Timeout counter width = $clog2(TIMEOUT_CYCLES+1). The counter saturates and is held at 0 outside RECV.
- All error and overrun pulses are registered and last exactly one cycle.

Optional Feature:
Macro PS2_GLITCH_FILTER_EN.
- Defined: a stability counter follows the synchronised PS2Clk. The filtered level changes only after the new level has been seen for FILTER_LEN consecutive cycles, so pulses shorter than FILTER_LEN cycles are ignored. Edge-detect latency grows by FILTER_LEN cycles.
- Data is sampled from the unfiltered synchronised PS2Data; PS/2 data is stable for the whole clock-low phase, so the extra latency does not affect sampling.
- Not defined: filter logic is absent and the filtered level equals the synchronised level.

Test Plan:
- Good frame: start 0, data 0x1C LSB-first, parity 0, stop 1; bench uses TIMEOUT_CYCLES=1000. Response: data_out=0x1C, data_valid=1 two cycles after the 11th edge is detected, no error pulses; data_ready=1 for one cycle clears data_valid.
- Parity error: the same frame with parity 1. Response: one parity_err pulse, data_valid stays 0, bit_count returns to 0.
- Stop error and stray edge: stop bit 0 gives one frame_err pulse and no data. An isolated edge with data=1 in IDLE changes nothing.
- Timeout: send 5 bits and then stop. frame_err pulses at exactly 1000 cycles after the last edge and bit_count=0. A following 0x5A frame is received correctly.
- Overrun: send 0x16 then 0x1E with data_ready=0. Response: data_out stays 0x16 and overrun pulses once. Repeat with data_ready=1 in the CHECK cycle: data_out becomes 0x1E with no overrun.
- Reset/glitch: rst=0 after 6 bits clears all state with no pulses. With PS2_GLITCH_FILTER_EN and FILTER_LEN=4, a 2-cycle low glitch on PS2Clk leaves bit_count unchanged.
